div16: RTL and testbench
========================

DIV16 -- requirements
Module: Div16

Interface
- REQ-001: WIDTH, 16, operand/result width; only 16 is supported.
- REQ-002: CLK  input  1  single clock; all state changes on rising edge.
- REQ-003: RESET  input  1  synchronous, active-high reset.
- REQ-004: START  input  1  request; sampled only in IDLE.
- REQ-005: A  input  16  dividend; captured with START.
- REQ-006: B  input  16  divisor; captured with START.
- REQ-007: BUSY  output  1  high while an operation is in progress (RUN state).
- REQ-008: DONE  output  1  one-cycle pulse marking the cycle in which results become valid.
- REQ-009: QUOT  output  16  quotient, registered.
- REQ-010: REM  output  16  remainder, registered.
- REQ-011: DIVZERO  output  1  high with DONE and held while B was zero for the completed operation.

Function
- REQ-012: SHALL implement iterative restoring division, one quotient bit per cycle, MSB first.
- REQ-013: SHALL use FSM states IDLE, RUN, FIN: IDLE->RUN on START with B!=0; IDLE->FIN on START with B==0; RUN->FIN after 16 iterations; FIN->IDLE unconditionally.
- REQ-014: SHALL capture A and B only in the IDLE cycle in which START is sampled high.
- REQ-015: SHALL ignore START in RUN and FIN; operands in flight are unaffected.
- REQ-016: SHALL hold BUSY high for exactly 16 cycles in RUN; BUSY low in IDLE and FIN.
- REQ-017: SHALL assert DONE for exactly one cycle (FIN), 17 cycles after the START sample cycle for B!=0 and 1 cycle after for B==0.
- REQ-018: Per iteration: partial remainder P = {P[14:0], next dividend bit}; trial D = P - divisor (17-bit incl. borrow); if no borrow then P=D, quotient bit 1; else P unchanged, quotient bit 0.
- REQ-019: SHALL update QUOT, REM and DIVZERO only on entry to FIN and hold them until the next FIN.
- REQ-020: Division by zero SHALL give QUOT=16'hFFFF, REM=A, DIVZERO=1.
- REQ-021: A < B SHALL give QUOT=0, REM=A; A==0 SHALL give QUOT=0, REM=0.

Reset
- REQ-022: RESET high SHALL force IDLE, iteration counter 0, BUSY=0, DONE=0, QUOT=0, REM=0, DIVZERO=0.
- REQ-023: RESET during RUN or FIN SHALL abort the operation; no DONE pulse is produced for it.
- REQ-024: RESET SHALL take priority over START in the same cycle.

Configuration
- REQ-025: Macro DIV16_SIGNED_EN; when undefined, A, B, QUOT and REM are unsigned.
- REQ-026: When DIV16_SIGNED_EN is defined: operands are two's complement; magnitudes are divided by the same unsigned core; quotient is truncated toward zero; REM takes the sign of A.
- REQ-027: With DIV16_SIGNED_EN, 16'h8000 / 16'hFFFF SHALL give QUOT=16'h8000, REM=0, DIVZERO=0; divide-by-zero gives QUOT=16'hFFFF, REM=A.
- REQ-028: Latency SHALL be identical with or without DIV16_SIGNED_EN; sign fix-up is applied on entry to FIN.

Structure
- REQ-029: Shared package SHALL hold the FSM state encoding (IDLE, RUN, FIN), WIDTH=16, the iteration count 16 and the divide-by-zero quotient constant 16'hFFFF.
- REQ-030: The trial subtraction SHALL be a sub-module Sub16: combinational 16-bit A-B with BORROW output, built from the existing adder cells (A + ~B + 1).
- REQ-031: Div16 SHALL contain only the FSM, counter, shift registers and result registers around Sub16.

Verification
- REQ-032: A=100, B=7, START 1 cycle -> BUSY 16 cycles, DONE 17 cycles after START; QUOT=14, REM=2, DIVZERO=0.
- REQ-033: A=16'hFFFF, B=1 -> QUOT=16'hFFFF, REM=0; then A=3, B=16'hFFFF -> QUOT=0, REM=3.
- REQ-034: A=5, B=0 -> DONE 1 cycle after START; QUOT=16'hFFFF, REM=5, DIVZERO=1; BUSY never high.
- REQ-035: START with A=50, B=5, then START with A=9, B=3 pulsed during RUN -> ignored; result QUOT=10, REM=0; only one DONE.
- REQ-036: RESET at iteration 8 of A=1000, B=3 -> outputs all 0, no DONE; next START A=1000, B=3 -> QUOT=333, REM=1.
- REQ-037: DIV16_SIGNED_EN defined, A=16'hFFF9 (-7), B=2 -> QUOT=16'hFFFD (-3), REM=16'hFFFF (-1).

Source files
------------

// File: rtl/div16_pkg.sv
// Shared definitions for the div16 iterative divider.
//   - state_e      : FSM state encoding (StIdle, StRun, StFin)
//   - Width        : operand/result width (only 16 is supported)
//   - Iters        : number of restoring iterations (one quotient bit each)
//   - DivZeroQuot  : quotient reported for a zero divisor
//   - cond_neg()   : conditional two's complement negate, used for signed fix-up
package div16_pkg;

  localparam int unsigned Width    = 16;
  localparam int unsigned Iters    = 16;
  localparam int unsigned CntWidth = $clog2(Iters);

  localparam logic [CntWidth-1:0] LastIter    = CntWidth'(Iters - 1);
  localparam logic [Width-1:0]    DivZeroQuot = 16'hFFFF;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_e;

  function automatic logic [Width-1:0] cond_neg(input logic [Width-1:0] v, input logic neg);
    return neg ? (~v + Width'(1)) : v;
  endfunction

endpackage

// File: rtl/div16_sub16.sv
// Trial subtractor for the divider: diff = a - b, computed as a + ~b + 1 on a
// single carry chain. borrow is the inverted carry-out, i.e. high when a < b.
//   a, b   : 16-bit unsigned operands
//   diff   : a - b modulo 2^16
//   borrow : 1 when a < b
module div16_sub16
  import div16_pkg::*;
(
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic [Width-1:0] diff,
  output logic             borrow
);

  logic [Width:0] sum;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, ~b} + {{Width{1'b0}}, 1'b1};
    diff   = sum[Width-1:0];
    borrow = ~sum[Width];
  end

endmodule

// File: rtl/div16.sv
// Iterative restoring divider, one quotient bit per cycle, MSB first.
// Optional feature macro: DIV16_SIGNED_EN -- when defined, operands and results are
// two's complement (quotient truncated toward zero, remainder takes the sign of a).
// Ports:
//   clk     : clock, rising edge
//   reset   : synchronous active-high reset (aborts any operation in flight)
//   start   : request, sampled only in idle
//   a, b    : dividend / divisor, captured with start
//   busy    : high for the 16 iteration cycles
//   done    : one-cycle pulse when quot/rem/divzero become valid
//   quot    : registered quotient
//   rem     : registered remainder
//   divzero : set with done when the completed operation had b == 0
module div16
  import div16_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Width-1:0] a,
  input  logic [Width-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] quot,
  output logic [Width-1:0] rem,
  output logic             divzero
);

`ifdef DIV16_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [Width-1:0]    dvd_q, dvd_d;   // dividend magnitude, shifted out MSB first
  logic [Width-1:0]    dvs_q, dvs_d;   // divisor magnitude
  logic [Width-1:0]    p_q, p_d;       // partial remainder
  logic [Width-1:0]    qb_q, qb_d;     // quotient bits collected so far
  logic                qneg_q, qneg_d; // negate quotient at the end
  logic                rneg_q, rneg_d; // negate remainder at the end
  logic [Width-1:0]    quot_q, quot_d;
  logic [Width-1:0]    rem_q, rem_d;
  logic                divz_q, divz_d;

  logic [Width-1:0] p_shift, diff, p_next, q_next;
  logic             borrow;
  logic             a_neg, b_neg;

  // After k iterations p < 2^k, so the bit dropped from p_q[15] is always zero.
  assign p_shift = {p_q[Width-2:0], dvd_q[Width-1]};

  div16_sub16 u_sub (
    .a      (p_shift),
    .b      (dvs_q),
    .diff   (diff),
    .borrow (borrow)
  );

  assign p_next = borrow ? p_shift : diff;
  assign q_next = {qb_q[Width-2:0], ~borrow};
  assign a_neg  = SignedEn && a[Width-1];
  assign b_neg  = SignedEn && b[Width-1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    p_d     = p_q;
    qb_d    = qb_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    divz_d  = divz_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (b == '0) begin
            // No iterations needed; results are known immediately.
            state_d = StFin;
            quot_d  = DivZeroQuot;
            rem_d   = a;
            divz_d  = 1'b1;
          end else begin
            state_d = StRun;
            cnt_d   = '0;
            dvd_d   = cond_neg(a, a_neg);
            dvs_d   = cond_neg(b, b_neg);
            p_d     = '0;
            qb_d    = '0;
            qneg_d  = a_neg ^ b_neg;
            rneg_d  = a_neg;
          end
        end
      end
      StRun: begin
        dvd_d = {dvd_q[Width-2:0], 1'b0};
        p_d   = p_next;
        qb_d  = q_next;
        cnt_d = cnt_q + CntWidth'(1);
        if (cnt_q == LastIter) begin
          state_d = StFin;
          quot_d  = cond_neg(q_next, qneg_q);
          rem_d   = cond_neg(p_next, rneg_q);
          divz_d  = 1'b0;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      p_q     <= '0;
      qb_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      p_q     <= p_d;
      qb_q    <= qb_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      divz_q  <= divz_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign done    = (state_q == StFin);
  assign quot    = quot_q;
  assign rem     = rem_q;
  assign divzero = divz_q;

endmodule

// File: tb/tb_div16.sv
// Directed self-checking bench for div16. Expected values are hand-computed;
// signed expectations apply when DIV16_SIGNED_EN is defined for the build.
module tb_div16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        busy;
  logic        done;
  logic [15:0] quot;
  logic [15:0] rem;
  logic        divzero;

  int checks   = 0;
  int failures = 0;

  // Per-operation observations collected by run_op.
  int lat;
  int nbusy;
  int ndone;

  always #5 clk = ~clk;

  div16 dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .quot    (quot),
    .rem     (rem),
    .divzero (divzero)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle with (ta, tb), then observe 22 cycles at negedges.
  // Cycle 1 is the first cycle after the start sample edge. Optionally pulse
  // start with other operands (inj_c) or assert reset (rst_c) in a given cycle.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v,
                        input int inj_c, input logic [15:0] ia, input logic [15:0] ib,
                        input int rst_c);
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    nbusy = 0;
    ndone = 0;
    for (int c = 1; c <= 22; c++) begin
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (lat == 0) lat = c;
      end
      start = 1'b0;
      reset = 1'b0;
      if (c == inj_c) begin
        start = 1'b1;
        a     = ia;
        b     = ib;
      end
      if (c == rst_c) reset = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 16'(busy), 16'd0);
    check("rst_done", 16'(done), 16'd0);
    check("rst_quot", quot, 16'd0);
    check("rst_rem", rem, 16'd0);
    check("rst_divz", 16'(divzero), 16'd0);
    reset = 1'b0;

    // 100 / 7
    run_op(16'd100, 16'd7, 0, '0, '0, 0);
    check("b7_lat", 16'(lat), 16'd17);
    check("b7_busy", 16'(nbusy), 16'd16);
    check("b7_ndone", 16'(ndone), 16'd1);
    check("b7_quot", quot, 16'd14);
    check("b7_rem", rem, 16'd2);
    check("b7_divz", 16'(divzero), 16'd0);

    run_op(16'hFFFF, 16'd1, 0, '0, '0, 0);
    check("max1_lat", 16'(lat), 16'd17);
    check("max1_quot", quot, 16'hFFFF);
    check("max1_rem", rem, 16'd0);

    run_op(16'd3, 16'hFFFF, 0, '0, '0, 0);
`ifdef DIV16_SIGNED_EN
    // 3 / -1 = -3 rem 0
    check("small_quot", quot, 16'hFFFD);
    check("small_rem", rem, 16'd0);
`else
    check("small_quot", quot, 16'd0);
    check("small_rem", rem, 16'd3);
`endif

    // divide by zero
    run_op(16'd5, 16'd0, 0, '0, '0, 0);
    check("dz_lat", 16'(lat), 16'd1);
    check("dz_busy", 16'(nbusy), 16'd0);
    check("dz_ndone", 16'(ndone), 16'd1);
    check("dz_quot", quot, 16'hFFFF);
    check("dz_rem", rem, 16'd5);
    check("dz_divz", 16'(divzero), 16'd1);

    // start pulsed during run is ignored
    run_op(16'd50, 16'd5, 5, 16'd9, 16'd3, 0);
    check("ign_lat", 16'(lat), 16'd17);
    check("ign_ndone", 16'(ndone), 16'd1);
    check("ign_quot", quot, 16'd10);
    check("ign_rem", rem, 16'd0);
    check("ign_divz", 16'(divzero), 16'd0);

    // reset mid-run aborts
    run_op(16'd1000, 16'd3, 0, '0, '0, 8);
    check("abort_ndone", 16'(ndone), 16'd0);
    check("abort_busy", 16'(busy), 16'd0);
    check("abort_quot", quot, 16'd0);
    check("abort_rem", rem, 16'd0);
    check("abort_divz", 16'(divzero), 16'd0);

    run_op(16'd1000, 16'd3, 0, '0, '0, 0);
    check("k_lat", 16'(lat), 16'd17);
    check("k_quot", quot, 16'd333);
    check("k_rem", rem, 16'd1);

    // zero dividend
    run_op(16'd0, 16'd9, 0, '0, '0, 0);
    check("zero_quot", quot, 16'd0);
    check("zero_rem", rem, 16'd0);

    // reset wins over start in the same cycle
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    a     = 16'd10;
    b     = 16'd2;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("prio_busy", 16'(busy), 16'd0);
    check("prio_done", 16'(done), 16'd0);
    @(negedge clk);
    check("prio_busy2", 16'(busy), 16'd0);
    check("prio_done2", 16'(done), 16'd0);

`ifdef DIV16_SIGNED_EN
    run_op(16'hFFF9, 16'd2, 0, '0, '0, 0);
    check("s_quot", quot, 16'hFFFD);
    check("s_rem", rem, 16'hFFFF);
    check("s_lat", 16'(lat), 16'd17);
    run_op(16'h8000, 16'hFFFF, 0, '0, '0, 0);
    check("s_min_quot", quot, 16'h8000);
    check("s_min_rem", rem, 16'd0);
    check("s_min_divz", 16'(divzero), 16'd0);
    run_op(16'hFFF9, 16'd0, 0, '0, '0, 0);
    check("s_dz_quot", quot, 16'hFFFF);
    check("s_dz_rem", rem, 16'hFFF9);
    check("s_dz_divz", 16'(divzero), 16'd1);
`else
    // 65529 / 2 = 32764 rem 1
    run_op(16'hFFF9, 16'd2, 0, '0, '0, 0);
    check("u_quot", quot, 16'h7FFC);
    check("u_rem", rem, 16'd1);
    check("u_lat", 16'(lat), 16'd17);
    run_op(16'h8000, 16'hFFFF, 0, '0, '0, 0);
    check("u_big_quot", quot, 16'd0);
    check("u_big_rem", rem, 16'h8000);
    check("u_big_divz", 16'(divzero), 16'd0);
    run_op(16'hFFFF, 16'hFFFF, 0, '0, '0, 0);
    check("u_eq_quot", quot, 16'd1);
    check("u_eq_rem", rem, 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
